// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Architectural register file with rename tags for the out-of-order RV32I
// core. Each register x0..x31 holds its retired value plus a busy bit and the
// id of the reorder-buffer entry that will produce its next value.
//
// The reorder buffer writes the file:
//   * launch : at dispatch, tags a destination register with its producer id
//   * commit : at retirement, writes the value and drops the tag if it is
//              still the one the retiring entry owns
//   * clear  : on a pipeline flush, drops every tag and keeps the values
// The decoder reads two operands combinationally.
//
// Optional feature macro: REGFILE_COMMIT_BYPASS_EN
//   defined   : a read that hits a same-cycle commit returns the commit value
//               and, if the commit retires the current producer, busy=0/dep=0
//   undefined : reads show registered state only
//
// Ports
//   clk_in                  system clock
//   rst_in                  synchronous reset, active-high
//   rdy_in                  low => no state changes, read ports stay valid
//   _clear                  pipeline flush from the ROB
//   _rf_launch_ready        allocate a tag
//   _rf_launch_rob_id       producing ROB id (1..31)
//   _rf_launch_register_id  destination register of the launch
//   _rf_commit_ready        retire write
//   _rf_commit_rob_id       retiring ROB id
//   _rf_commit_register_id  destination register of the commit
//   _rf_commit_value        retired value
//   _rf_query_reg_1/2       decoder operand indices
//   _rf_busy_1/2            operand awaits an in-flight producer
//   _rf_dep_1/2             producing ROB id (0 when not busy)
//   _rf_value_1/2           architectural value
// -----------------------------------------------------------------------------
module register_file #(
    parameter int REG_NUM  = 32,
    parameter int ROB_ID_W = 5
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,

    input  logic                       _clear,

    input  logic                       _rf_launch_ready,
    input  logic [ROB_ID_W-1:0]        _rf_launch_rob_id,
    input  logic [$clog2(REG_NUM)-1:0] _rf_launch_register_id,

    input  logic                       _rf_commit_ready,
    input  logic [ROB_ID_W-1:0]        _rf_commit_rob_id,
    input  logic [$clog2(REG_NUM)-1:0] _rf_commit_register_id,
    input  logic [31:0]                _rf_commit_value,

    input  logic [$clog2(REG_NUM)-1:0] _rf_query_reg_1,
    input  logic [$clog2(REG_NUM)-1:0] _rf_query_reg_2,

    output logic                       _rf_busy_1,
    output logic [ROB_ID_W-1:0]        _rf_dep_1,
    output logic [31:0]                _rf_value_1,

    output logic                       _rf_busy_2,
    output logic [ROB_ID_W-1:0]        _rf_dep_2,
    output logic [31:0]                _rf_value_2
);

    localparam int IDX_W = $clog2(REG_NUM);
    localparam int XLEN  = 32;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [XLEN-1:0]     r_value [REG_NUM];
    logic [REG_NUM-1:0]  r_busy;
    logic [ROB_ID_W-1:0] r_dep   [REG_NUM];

    // -------------------------------------------------------------------------
    // Write qualifiers
    // -------------------------------------------------------------------------
    logic w_commit_en;
    logic w_launch_en;
    logic w_commit_owns_tag;

    // Writes to x0 are discarded here so x0 state never leaves its reset value.
    assign w_commit_en = rdy_in & _rf_commit_ready
                       & (_rf_commit_register_id != '0);

    // A launch in a flush cycle belongs to the squashed path and is dropped.
    assign w_launch_en = rdy_in & _rf_launch_ready & ~_clear
                       & (_rf_launch_register_id != '0);

    // The retiring entry only releases the register if it is still the newest
    // producer; otherwise a younger launch has taken ownership of the tag.
    assign w_commit_owns_tag = r_busy[_rf_commit_register_id]
                             & (r_dep[_rf_commit_register_id] == _rf_commit_rob_id);

    // -------------------------------------------------------------------------
    // Register update
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the value array is reset on purpose -- every read port must
            // show 0 after reset, so this storage cannot be left as plain RAM.
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_dep[i]   <= '0;
            end
            r_busy <= '0;
        end else if (rdy_in) begin
            // The commit value is written even during a flush: the retiring
            // instruction is the one that triggered it.
            if (w_commit_en) begin
                r_value[_rf_commit_register_id] <= _rf_commit_value;
            end

            if (_clear) begin
                r_busy <= '0;
                for (int i = 0; i < REG_NUM; i++) begin
                    r_dep[i] <= '0;
                end
            end else begin
                if (w_commit_en && w_commit_owns_tag) begin
                    r_busy[_rf_commit_register_id] <= 1'b0;
                    r_dep[_rf_commit_register_id]  <= '0;
                end
                // NOTE: non-blocking assignments -- when launch and commit hit
                // the same register, the later launch assignment below is the
                // one that lands, so the new tag overrides the tag-clear.
                if (w_launch_en) begin
                    r_busy[_rf_launch_register_id] <= 1'b1;
                    r_dep[_rf_launch_register_id]  <= _rf_launch_rob_id;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]    w_query [2];
    logic                w_busy  [2];
    logic [ROB_ID_W-1:0] w_dep   [2];
    logic [XLEN-1:0]     w_value [2];

    assign w_query[0] = _rf_query_reg_1;
    assign w_query[1] = _rf_query_reg_2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_busy[p]  = r_busy[w_query[p]];
            w_dep[p]   = r_dep[w_query[p]];
            w_value[p] = r_value[w_query[p]];

`ifdef REGFILE_COMMIT_BYPASS_EN
            // Forward a same-cycle commit. A same-cycle launch is deliberately
            // not forwarded: the decoder reading in this cycle is older than it.
            if (w_commit_en && (w_query[p] == _rf_commit_register_id)) begin
                w_value[p] = _rf_commit_value;
                if (w_busy[p] && (w_dep[p] == _rf_commit_rob_id)) begin
                    w_busy[p] = 1'b0;
                    w_dep[p]  = '0;
                end
            end
`endif

            // x0 is hard-wired to zero regardless of stored state.
            if (w_query[p] == '0) begin
                w_busy[p]  = 1'b0;
                w_dep[p]   = '0;
                w_value[p] = '0;
            end
        end
    end

    assign _rf_busy_1  = w_busy[0];
    assign _rf_dep_1   = w_dep[0];
    assign _rf_value_1 = w_value[0];

    assign _rf_busy_2  = w_busy[1];
    assign _rf_dep_2   = w_dep[1];
    assign _rf_value_2 = w_value[1];

endmodule
